alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle shift-add multiplier controller that time-shares one 32-bit `ALU` instance, permanently configured as an adder, to form a 64-bit product. It sits beside the single-cycle `ALU` in the execute stage. It accepts a start request, sequences 32 add/shift iterations through the `ALU`, and returns the product with a one-cycle done pulse. It is the first multi-cycle resource in the datapath and the template for a later divider.

## Interface
Parameters:
- `ITER`, default 32: iteration count; must equal operand width, and is fixed at 32 for the `ALU`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request; sampled only in IDLE.
- `src_a_i`  in  32  multiplicand; captured on accept.
- `src_b_i`  in  32  multiplier; captured on accept.
- `busy_o`  out  1  high from the cycle after accept through the DONE cycle.
- `done_o`  out  1  one-cycle pulse; `product_o` is valid in the same cycle.
- `product_o`  out  64  result; holds until the next accept.
- `zero_o`  out  1  `product_o == 0`; registered with `product_o`.

## Operation
- Internal registers:
  - `mcand[31:0]`, `hi[31:0]`, `lo[31:0]`, `cnt[5:0]`.
  - State: IDLE, RUN, DONE (plus NEG, see Configuration).
- The `ALU` instance is tied to `aluSrc1=hi`, `aluSrc2=mcand`, `invertA=0`, `invertB=0`, `operation=2'b10` (add).
  - `ALU` `zero` and `overflow` are unused.
- The `ALU` does not export a carry. Unsigned carry-out is derived as `c = (hi[31]&mcand[31]) | ((hi[31]^mcand[31]) & ~sum[31])`, where `sum` is the `ALU` result.
- IDLE:
  - If `start_i`=1: `mcand<=src_a_i`, `lo<=src_b_i`, `hi<=0`, `cnt<=0`, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - If `lo[0]`: `{hi,lo} <= {c, sum, lo[31:1]}`.
  - Else: `{hi,lo} <= {1'b0, hi, lo[31:1]}`.
  - `cnt<=cnt+1`.
  - When `cnt==ITER-1`, go to DONE after this update.
- DONE:
  - `product_o <= {hi,lo}` is registered on entry, so it is visible in the DONE cycle.
  - `done_o`=1; then go to IDLE unconditionally.
- `start_i` is ignored while in RUN, DONE or NEG. There is no queueing; the requester must wait for `done_o`.
- Arithmetic is unsigned modulo 2^64. It cannot overflow, since 32×32 fits in 64 bits.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=IDLE, `busy_o`=0, `done_o`=0, `product_o`=0, `zero_o`=1.
  - `mcand`, `hi`, `lo`, `cnt` = 0.
- Accept edge E0 (IDLE with `start_i`=1): `busy_o`=1 from E0.
- RUN occupies the cycles after edges E0..E31.
- The DONE cycle follows edge E32:
  - `done_o`=1 and `product_o` valid.
  - Unsigned latency: 33 cycles from accept to `done_o`.
- Back-to-back operation: the earliest next accept is the IDLE cycle after DONE. The minimum issue interval is 34 cycles.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is aborted and `done_o` is never raised.
  - `product_o` reverts to 0.
- `start_i` held high continuously: accepted once per IDLE visit only.

## Configuration
- `ALU_MUL_SEQ_SIGNED_EN`:
  - **Defined:**
    - Adds input `signed_i` (1 bit), sampled with `start_i`.
    - When `signed_i`=1, on accept the block loads `|src_a_i|` and `|src_b_i|` and stores `neg = src_a_i[31]^src_b_i[31]`.
    - A NEG state is inserted between RUN and DONE for every operation, signed or not. In NEG, `{hi,lo} <= neg ? ~{hi,lo}+1 : {hi,lo}`.
    - Latency is a constant 34 cycles; the minimum issue interval is 35 cycles.
    - `-2^31` magnitude is handled as unsigned 0x80000000.
  - **Undefined:**
    - No `signed_i` port and no NEG state.
    - Unsigned only, with 33-cycle latency.

## Test plan
- Reset, then `rst_n` released → `busy_o`=0, `done_o`=0, `product_o`=0, `zero_o`=1.
- `start_i` with A=0x0000_0007, B=0x0000_0006 → `done_o` exactly 33 cycles after accept, `product_o`=0x0000_0000_0000_002A, `zero_o`=0, `done_o` high for one cycle only.
- A=B=0xFFFF_FFFF → `product_o`=0xFFFF_FFFE_0000_0001. This exercises the derived carry on every iteration.
- A=0x1234_5678, B=0 → `product_o`=0, `zero_o`=1. A second `start_i` pulse at accept+5 is ignored: only one `done_o`, and no restart.
- Reset asserted at accept+10 → outputs return to reset values immediately. A fresh start with A=3, B=5 then yields 0xF after 33 cycles.
- With `ALU_MUL_SEQ_SIGNED_EN`:
  - `signed_i`=1, A=0xFFFF_FFFD (-3), B=5 → `product_o`=0xFFFF_FFFF_FFFF_FFF1 at 34 cycles.
  - A=B=0x8000_0000 → 0x4000_0000_0000_0000.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// With ALU_MUL_SEQ_SIGNED_EN defined, the bundle also carries signed_i.
interface alu_mul_seq_if;
  logic        start_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic        signed_i;
`endif
  logic        busy_o;
  logic        done_o;
  logic [63:0] product_o;
  logic        zero_o;

  // Requester side
  modport master (
    output start_i,
    output src_a_i,
    output src_b_i,
`ifdef ALU_MUL_SEQ_SIGNED_EN
    output signed_i,
`endif
    input  busy_o,
    input  done_o,
    input  product_o,
    input  zero_o
  );

  // Multiplier side
  modport slave (
    input  start_i,
    input  src_a_i,
    input  src_b_i,
`ifdef ALU_MUL_SEQ_SIGNED_EN
    input  signed_i,
`endif
    output busy_o,
    output done_o,
    output product_o,
    output zero_o
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier that time-shares one 32-bit ALU set to add.
// Produces a 64-bit unsigned product 33 cycles after accept.
// Optional feature macro: ALU_MUL_SEQ_SIGNED_EN adds signed_i and a NEG state
// (constant 34-cycle latency for every operation).
module alu_mul_seq #(
  parameter int unsigned ITER = 32
) (
  input  logic          clk_i,
  input  logic          rst_n,
  alu_mul_seq_if.slave  bus
);
  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mcand, mcand_d;
  logic [W-1:0]    hi, hi_d;
  logic [W-1:0]    lo, lo_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*W-1:0]  product_q;
  logic            zero_q;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic            neg, neg_d;
`endif

  logic [W-1:0]    sum;
  logic            carry;
  logic            alu_zero_unused;
  logic            alu_ovf_unused;
  logic            unused_ok;

  // Shared adder: hi + mcand every cycle
  ALU u_alu (
    .aluSrc1   (hi),
    .aluSrc2   (mcand),
    .invertA   (1'b0),
    .invertB   (1'b0),
    .operation (2'b10),
    .result    (sum),
    .zero      (alu_zero_unused),
    .overflow  (alu_ovf_unused)
  );

  assign unused_ok = &{1'b0, alu_zero_unused, alu_ovf_unused};

  // Unsigned carry-out reconstructed from operand and sum MSBs
  assign carry = (hi[W-1] & mcand[W-1]) | ((hi[W-1] ^ mcand[W-1]) & ~sum[W-1]);

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start_i) state_d = S_RUN;
      S_RUN: begin
        if (cnt == CNT_LAST) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
          state_d = S_NEG;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      S_NEG:  state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mcand_d = mcand;
    hi_d    = hi;
    lo_d    = lo;
    cnt_d   = cnt;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    neg_d   = neg;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          mcand_d = bus.src_a_i;
          lo_d    = bus.src_b_i;
          hi_d    = '0;
          cnt_d   = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
          neg_d   = 1'b0;
          if (bus.signed_i) begin
            // Magnitudes; 0x80000000 maps to itself and is treated as unsigned
            if (bus.src_a_i[W-1]) mcand_d = ~bus.src_a_i + W'(1);
            if (bus.src_b_i[W-1]) lo_d    = ~bus.src_b_i + W'(1);
            neg_d = bus.src_a_i[W-1] ^ bus.src_b_i[W-1];
          end
`endif
        end
      end
      S_RUN: begin
        if (lo[0]) {hi_d, lo_d} = {carry, sum, lo[W-1:1]};
        else       {hi_d, lo_d} = {1'b0, hi, lo[W-1:1]};
        cnt_d = cnt + CNT_W'(1);
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      S_NEG: begin
        if (neg) {hi_d, lo_d} = ~{hi, lo} + (2*W)'(1);
      end
`endif
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath and registered outputs; product captured on entry to DONE
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      zero_q    <= 1'b1;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      mcand  <= mcand_d;
      hi     <= hi_d;
      lo     <= lo_d;
      cnt    <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      neg    <= neg_d;
`endif
      if (done_d) begin
        product_q <= {hi_d, lo_d};
        zero_q    <= ({hi_d, lo_d} == '0);
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.product_o = product_q;
  assign bus.zero_o    = zero_q;
endmodule

// Single-cycle 32-bit ALU: and / or / add / set-less-than with operand inversion
module ALU (
  input  logic [31:0] aluSrc1,
  input  logic [31:0] aluSrc2,
  input  logic        invertA,
  input  logic        invertB,
  input  logic [1:0]  operation,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] add_res;

  // Operand conditioning, adder and result select
  always_comb begin
    op_a     = invertA ? ~aluSrc1 : aluSrc1;
    op_b     = invertB ? ~aluSrc2 : aluSrc2;
    add_res  = op_a + op_b + 32'(invertB);
    overflow = (op_a[31] == op_b[31]) && (add_res[31] != op_a[31]);
    unique case (operation)
      2'b00:   result = op_a & op_b;
      2'b01:   result = op_a | op_b;
      2'b10:   result = add_res;
      default: result = {31'd0, add_res[31] ^ overflow};
    endcase
    zero = (result == 32'd0);
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq.
module tb_alu_mul_seq;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_mul_seq_if bus ();

  alu_mul_seq #(.ITER(32)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Wait for a done pulse; n = edges waited (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.done_o === 1'b1) return;
    end
    n = 999;
  endtask

  // Accept one operation, check latency and result; optional extra start at pulse_at
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int pulse_at);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.src_a_i = a;
    bus.src_b_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check({tag, "_busy_accept"}, 64'(bus.busy_o), 64'd1);
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 100) begin
      bus.start_i = (n == pulse_at);
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) seen = 1'b1;
      else n++;
    end
    bus.start_i = 1'b0;
    check({tag, "_latency"}, 64'(n + 1), 64'(LAT));
    check({tag, "_product"}, bus.product_o, exp);
    check({tag, "_zero"}, 64'(bus.zero_o), 64'(exp == 64'd0));
    check({tag, "_busy_done"}, 64'(bus.busy_o), 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
    check({tag, "_hold"}, bus.product_o, exp);
  endtask

  initial begin
    int n;
    int dones;
    checks   = 0;
    failures = 0;
    rst_n       = 1'b1;
    bus.start_i = 1'b0;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    bus.signed_i = 1'b0;
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_product", bus.product_o, 64'd0);
    check("rst_zero", 64'(bus.zero_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul7x6", 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, -1);
    run_op("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);

    // Reset during RUN aborts the operation
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.src_a_i = 32'd5;
    bus.src_b_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy_o), 64'd0);
    check("abort_done", 64'(bus.done_o), 64'd0);
    check("abort_product", bus.product_o, 64'd0);
    check("abort_zero", 64'(bus.zero_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    run_op("mul3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, -1);

    // Zero product with an ignored start pulse at accept+5
    run_op("mulzero", 32'h1234_5678, 32'h0000_0000, 64'd0, 5);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) dones++;
    end
    check("ignored_start_no_done", 64'(dones), 64'd0);
    check("ignored_start_idle", 64'(bus.busy_o), 64'd0);

    // start_i held high: back-to-back issue interval
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.src_a_i = 32'd2;
    bus.src_b_i = 32'd3;
    wait_done(n);
    check("b2b_first", 64'(n < 999), 64'd1);
    wait_done(n);
    bus.start_i = 1'b0;
    check("b2b_interval", 64'(n), 64'(LAT + 1));
    check("b2b_product", bus.product_o, 64'd6);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_stop", 64'(bus.busy_o), 64'd0);

`ifdef ALU_MUL_SEQ_SIGNED_EN
    bus.signed_i = 1'b1;
    run_op("sneg3x5", 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1);
    run_op("smin2", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
    bus.signed_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
